epsilon_greedy_action_select: RTL and testbench



---
 rtl/dqn_pkg.sv | 28 ++
 rtl/lfsr_galois16.sv | 18 +
 rtl/epsilon_greedy_action_select.sv | 98 +++++++++
 tb/tb_epsilon_greedy_action_select.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dqn_pkg.sv
// Shared definitions for the DQN action-selection and replay-sampling blocks.
package dqn_pkg;

  localparam int          DQN_ACTION_W    = 2;
  localparam int          DQN_NUM_ACTIONS = 3;
  localparam int          DQN_EPS_W       = 16;

  // Galois feedback mask for the 16-bit right-shifting LFSR
  localparam logic [15:0] DQN_LFSR_POLY   = 16'hB400;
  localparam logic [15:0] DQN_LFSR_SEED   = 16'hACE1;

  // Epsilon schedule defaults (unsigned fraction, 0xFFFF ~ 1.0)
  localparam logic [15:0] DQN_EPS_START   = 16'hFFFF;
  localparam logic [15:0] DQN_EPS_MIN     = 16'h0CCC;
  localparam logic [15:0] DQN_EPS_STEP    = 16'h0010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECIDE = 2'd1,
    ST_HOLD   = 2'd2
  } sel_state_t;

  // One step of the Galois LFSR; a nonzero state never maps to zero
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? DQN_LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr_galois16.sv
// Free-running 16-bit Galois LFSR, advances every non-reset cycle.
module lfsr_galois16
  import dqn_pkg::*;
#(
  parameter logic [15:0] SEED = DQN_LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  // Load the seed on reset, otherwise step the sequence
  always_ff @(posedge clk) begin
    if (rst) state <= SEED;
    else     state <= lfsr_next(state);
  end

endmodule

// File: rtl/epsilon_greedy_action_select.sv
// Epsilon-greedy exploration stage behind the arg-max block, with decaying
// epsilon and a valid/ready action output.
module epsilon_greedy_action_select
  import dqn_pkg::*;
#(
  parameter int                     NUMBER_OF_ACTIONS  = DQN_NUM_ACTIONS,
  parameter int                     ACTION_WIDTH       = DQN_ACTION_W,
  parameter int                     EPSILON_WIDTH      = DQN_EPS_W,
  parameter logic [EPSILON_WIDTH-1:0] EPSILON_START    = DQN_EPS_START,
  parameter logic [EPSILON_WIDTH-1:0] EPSILON_MIN      = DQN_EPS_MIN,
  parameter logic [EPSILON_WIDTH-1:0] EPSILON_DECAY_STEP = DQN_EPS_STEP,
  parameter logic [15:0]            LFSR_SEED          = DQN_LFSR_SEED
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ACTION_WIDTH-1:0]  i_arg_max,
  input  logic                     i_arg_max_valid,
  input  logic                     i_explore_enable,
  input  logic                     i_episode_done,
  input  logic                     i_action_ready,
  output logic [ACTION_WIDTH-1:0]  o_action,
  output logic                     o_action_valid,
  output logic                     o_action_random,
  output logic [EPSILON_WIDTH-1:0] o_epsilon,
  output logic                     o_overrun
);

  sel_state_t              state;
  logic [ACTION_WIDTH-1:0] greedy_q;
  logic [15:0]             lfsr_q;
  logic                    explore;
  logic [ACTION_WIDTH-1:0] rand_action;

  // Subtract one decay step, clamping at the floor without wrapping
  function automatic logic [EPSILON_WIDTH-1:0] decay_sat(input logic [EPSILON_WIDTH-1:0] eps);
    logic [EPSILON_WIDTH:0] thresh;
    thresh = {1'b0, EPSILON_MIN} + {1'b0, EPSILON_DECAY_STEP};
    if ({1'b0, eps} >= thresh) return eps - EPSILON_DECAY_STEP;
    else                       return EPSILON_MIN;
  endfunction

  lfsr_galois16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr_q)
  );

  // Decision terms use the current LFSR and pre-decay epsilon
  always_comb begin
    explore     = i_explore_enable && (lfsr_q < o_epsilon);
    // Scale the low LFSR byte into 0..N-1 by multiply-and-shift
    rand_action = ACTION_WIDTH'(({{ACTION_WIDTH{1'b0}}, lfsr_q[7:0]}
                  * (8 + ACTION_WIDTH)'(NUMBER_OF_ACTIONS)) >> 8);
  end

  // Capture / decide / hold controller with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      greedy_q        <= '0;
      o_action        <= '0;
      o_action_valid  <= 1'b0;
      o_action_random <= 1'b0;
      o_overrun       <= 1'b0;
    end else begin
      // Strobes arriving outside IDLE are dropped and flagged
      o_overrun <= i_arg_max_valid && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (i_arg_max_valid) begin
            greedy_q <= i_arg_max;
            state    <= ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          o_action        <= explore ? rand_action : greedy_q;
          o_action_random <= explore;
          o_action_valid  <= 1'b1;
          state           <= ST_HOLD;
        end
        ST_HOLD: begin
          if (i_action_ready) begin
            o_action_valid <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Epsilon register, decayed once per episode strobe
  always_ff @(posedge clk) begin
    if (rst)                 o_epsilon <= EPSILON_START;
    else if (i_episode_done) o_epsilon <= decay_sat(o_epsilon);
  end

endmodule

// File: tb/tb_epsilon_greedy_action_select.sv
// Directed bench for epsilon_greedy_action_select.
module tb_epsilon_greedy_action_select;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: default parameters
  logic        rst, arg_vld, explore_en, ep_done, ready;
  logic [1:0]  arg_max;
  logic [1:0]  act1;
  logic        vld1, rnd1, ovr1;
  logic [15:0] eps1;

  // Instances 2 and 3 share one input set
  logic        rst_b, vld_b, exp_b, ep_b, rdy_b;
  logic [1:0]  arg_b;
  logic [1:0]  act2, act3;
  logic        vld2, rnd2, ovr2, vld3, rnd3, ovr3;
  logic [15:0] eps2, eps3;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] model_lfsr;
  logic [15:0] model_eps;

  epsilon_greedy_action_select dut1 (
    .clk(clk), .rst(rst), .i_arg_max(arg_max), .i_arg_max_valid(arg_vld),
    .i_explore_enable(explore_en), .i_episode_done(ep_done), .i_action_ready(ready),
    .o_action(act1), .o_action_valid(vld1), .o_action_random(rnd1),
    .o_epsilon(eps1), .o_overrun(ovr1)
  );

  // Seed chosen so the first DECIDE after release sees lfsr = 0x00F0
  epsilon_greedy_action_select #(
    .EPSILON_START(16'h0100), .EPSILON_MIN(16'h0018),
    .EPSILON_DECAY_STEP(16'h0010), .LFSR_SEED(16'h01E0)
  ) dut2 (
    .clk(clk), .rst(rst_b), .i_arg_max(arg_b), .i_arg_max_valid(vld_b),
    .i_explore_enable(exp_b), .i_episode_done(ep_b), .i_action_ready(rdy_b),
    .o_action(act2), .o_action_valid(vld2), .o_action_random(rnd2),
    .o_epsilon(eps2), .o_overrun(ovr2)
  );

  epsilon_greedy_action_select #(
    .EPSILON_START(16'h0020), .EPSILON_MIN(16'h0018), .EPSILON_DECAY_STEP(16'h0010)
  ) dut3 (
    .clk(clk), .rst(rst_b), .i_arg_max(arg_b), .i_arg_max_valid(vld_b),
    .i_explore_enable(exp_b), .i_episode_done(ep_b), .i_action_ready(rdy_b),
    .o_action(act3), .o_action_valid(vld3), .o_action_random(rnd3),
    .o_epsilon(eps3), .o_overrun(ovr3)
  );

  // Reference LFSR for instance 1
  always @(posedge clk) begin
    if (rst) model_lfsr <= 16'hACE1;
    else     model_lfsr <= (model_lfsr >> 1) ^ (model_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance 1 with ready high; starts just after a negedge
  task automatic decide(input logic [1:0] g, input logic en);
    logic [15:0] l;
    logic        ex;
    logic [9:0]  p;
    logic [1:0]  ea;
    arg_max = g; arg_vld = 1'b1; explore_en = en; ready = 1'b1;
    @(negedge clk);
    arg_vld = 1'b0;
    check_eq("decide_valid_early", {31'd0, vld1}, 0);
    l  = model_lfsr;
    ex = en && (l < model_eps);
    p  = {2'b00, l[7:0]} * 10'd3;
    ea = ex ? p[9:8] : g;
    @(negedge clk);
    check_eq("decide_valid", {31'd0, vld1}, 1);
    check_eq("decide_action", {30'd0, act1}, {30'd0, ea});
    check_eq("decide_random", {31'd0, rnd1}, {31'd0, ex});
    @(negedge clk);
    check_eq("decide_valid_drop", {31'd0, vld1}, 0);
  endtask

  initial begin
    rst = 1'b1; arg_vld = 1'b0; explore_en = 1'b1; ep_done = 1'b0; ready = 1'b1; arg_max = 2'd0;
    rst_b = 1'b1; vld_b = 1'b0; exp_b = 1'b1; ep_b = 1'b0; rdy_b = 1'b1; arg_b = 2'd0;
    model_eps = 16'hFFFF;
    repeat (3) @(negedge clk);

    // Reset values
    check_eq("rst_action", {30'd0, act1}, 0);
    check_eq("rst_valid", {31'd0, vld1}, 0);
    check_eq("rst_random", {31'd0, rnd1}, 0);
    check_eq("rst_overrun", {31'd0, ovr1}, 0);
    check_eq("rst_eps1", {16'd0, eps1}, 32'hFFFF);
    check_eq("rst_eps2", {16'd0, eps2}, 32'h0100);
    check_eq("rst_eps3", {16'd0, eps3}, 32'h0020);
    check_eq("rst_valid2", {31'd0, vld2 | vld3 | rnd2 | rnd3 | ovr2 | ovr3}, 0);
    check_eq("rst_action23", {30'd0, act2 | act3}, 0);

    // Exploration determinism right after release: DECIDE sees 0x7138
    rst = 1'b0;
    @(negedge clk);
    decide(2'd1, 1'b1);
    check_eq("first_explore_action", {30'd0, act1}, 0);
    check_eq("first_explore_random", {31'd0, rnd1}, 1);
    for (int i = 0; i < 1000; i++) decide(2'(i % 3), 1'b1);
    check_eq("eps_no_decay", {16'd0, eps1}, 32'hFFFF);

    // Greedy path, including an out-of-range index passed through
    decide(2'd2, 1'b0);
    check_eq("greedy_action_hold", {30'd0, act1}, 2);
    decide(2'd3, 1'b0);

    // Backpressure and overrun
    arg_max = 2'd1; arg_vld = 1'b1; explore_en = 1'b0; ready = 1'b0;
    @(negedge clk); arg_vld = 1'b0;
    @(negedge clk);
    check_eq("bp_valid", {31'd0, vld1}, 1);
    check_eq("bp_action", {30'd0, act1}, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_hold_valid", {31'd0, vld1}, 1);
      check_eq("bp_hold_action", {30'd0, act1}, 1);
      check_eq("bp_overrun", {31'd0, ovr1}, (i == 2) ? 1 : 0);
      arg_max = 2'd0;
      arg_vld = (i == 1);
    end
    arg_vld = 1'b1; ready = 1'b1;
    @(negedge clk);
    arg_vld = 1'b0;
    check_eq("hs_valid_drop", {31'd0, vld1}, 0);
    check_eq("hs_overrun", {31'd0, ovr1}, 1);
    check_eq("hs_action_kept", {30'd0, act1}, 1);
    @(negedge clk);
    check_eq("hs_overrun_clear", {31'd0, ovr1}, 0);
    @(negedge clk);
    check_eq("hs_dropped_no_valid", {31'd0, vld1}, 0);

    // Reset while holding an action
    arg_max = 2'd2; arg_vld = 1'b1; ready = 1'b0;
    @(negedge clk); arg_vld = 1'b0;
    @(negedge clk);
    check_eq("mid_hold_valid", {31'd0, vld1}, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", {31'd0, vld1}, 0);
    check_eq("mid_rst_action", {30'd0, act1}, 0);
    check_eq("mid_rst_eps", {16'd0, eps1}, 32'hFFFF);
    rst = 1'b0;
    @(negedge clk);
    decide(2'd1, 1'b1);
    check_eq("after_rst_action", {30'd0, act1}, 0);
    check_eq("after_rst_random", {31'd0, rnd1}, 1);

    // 200 decay steps from 0xFFFF
    ep_done = 1'b1;
    repeat (200) @(negedge clk);
    ep_done = 1'b0;
    check_eq("decay_200", {16'd0, eps1}, 32'hF37F);
    @(negedge clk);
    check_eq("decay_idle", {16'd0, eps1}, 32'hF37F);

    // Decay coincident with DECIDE; floor saturation on instance 3
    rst_b = 1'b0; vld_b = 1'b1; arg_b = 2'd1; exp_b = 1'b1; rdy_b = 1'b1;
    @(negedge clk);
    vld_b = 1'b0; ep_b = 1'b1;
    check_eq("sim_valid_early", {31'd0, vld2}, 0);
    @(negedge clk);
    ep_b = 1'b0;
    check_eq("sim_valid", {31'd0, vld2}, 1);
    check_eq("sim_action", {30'd0, act2}, 2);
    check_eq("sim_random", {31'd0, rnd2}, 1);
    check_eq("sim_eps", {16'd0, eps2}, 32'h00F0);
    check_eq("sat_first", {16'd0, eps3}, 32'h0018);
    ep_b = 1'b1;
    repeat (3) @(negedge clk);
    ep_b = 1'b0;
    check_eq("sat_hold", {16'd0, eps3}, 32'h0018);
    check_eq("sim_eps_more", {16'd0, eps2}, 32'h00C0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
